// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, execute redirect and decode handshake.
// master is the fetch stage's view; slave is the memory/decode/execute side.
interface fetch_stage_if #(
    parameter int DATAWIDTH = 32
);
    logic                 imem_re_o;
    logic [DATAWIDTH-1:0] imem_raddr_o;
    logic [DATAWIDTH-1:0] imem_rdata_i;
    logic                 redirect_i;
    logic [DATAWIDTH-1:0] redirect_pc_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DATAWIDTH-1:0] inst_o;
    logic [DATAWIDTH-1:0] pc_o;

    modport master (
        output imem_re_o, imem_raddr_o, valid_o, inst_o, pc_o,
        input  imem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  imem_re_o, imem_raddr_o, valid_o, inst_o, pc_o,
        output imem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues imem reads under a credit limit,
// buffers {pc, inst} in a small FIFO for decode and flushes everything on redirect.
module fetch_stage #(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = {DATAWIDTH{1'b0}},
    parameter int                   DEPTH     = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [DATAWIDTH-1:0] PC_STEP    = {{(DATAWIDTH-3){1'b0}}, 3'b100};
    localparam logic [DATAWIDTH-1:0] ALIGN_MASK = {{(DATAWIDTH-2){1'b1}}, 2'b00};

    logic [DATAWIDTH-1:0] pc_q, pc_d;
    logic [DATAWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                 inflight_q, inflight_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [DATAWIDTH-1:0] pc_mem_q   [DEPTH];
    logic [DATAWIDTH-1:0] inst_mem_q [DEPTH];

    logic                 valid_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 issue_s;
    logic [CW:0]          occ_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + {{(PW-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Handshake and credit decode; reset level gates requests so they drop the instant reset asserts
    always_comb begin
        valid_s = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        issue_s = 1'b0;
        occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        if (rst_i && !bus.redirect_i) begin
            valid_s = (count_q != {CW{1'b0}});
            pop_s   = valid_s & bus.ready_i;
            push_s  = inflight_q;
            // Credit counts buffered plus in-flight, so a returning response always finds room
            occ_s   = occ_s - {{CW{1'b0}}, pop_s};
            issue_s = (occ_s < (CW+1)'(DEPTH));
        end else begin
            valid_s = 1'b0;
        end
    end

    // Next-state: redirect flushes the FIFO and drops the in-flight response
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        if (bus.redirect_i) begin
            pc_d    = bus.redirect_pc_i & ALIGN_MASK;
            count_d = {CW{1'b0}};
            rptr_d  = {PW{1'b0}};
            wptr_d  = {PW{1'b0}};
        end else begin
            if (issue_s) begin
                pc_d          = pc_q + PC_STEP;
                inflight_pc_d = pc_q;
                inflight_d    = 1'b1;
            end else begin
                inflight_d    = 1'b0;
            end
            if (push_s) begin
                wptr_d = next_ptr(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = next_ptr(rptr_q);
            end else begin
                rptr_d = rptr_q;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // State registers and FIFO storage
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= {DATAWIDTH{1'b0}};
            inflight_q    <= 1'b0;
            count_q       <= {CW{1'b0}};
            rptr_q        <= {PW{1'b0}};
            wptr_q        <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= {DATAWIDTH{1'b0}};
                inst_mem_q[i] <= {DATAWIDTH{1'b0}};
            end
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            if (push_s) begin
                pc_mem_q[wptr_q]   <= inflight_pc_q;
                inst_mem_q[wptr_q] <= bus.imem_rdata_i;
            end
        end
    end

    assign bus.imem_re_o    = issue_s;
    assign bus.imem_raddr_o = pc_q;
    assign bus.valid_o      = valid_s;
    assign bus.inst_o       = inst_mem_q[rptr_q];
    assign bus.pc_o         = pc_mem_q[rptr_q];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirects, PC wrap and async reset.
module tb_fetch_stage;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if #(.DATAWIDTH(32)) if0 ();
    fetch_stage_if #(.DATAWIDTH(32)) if1 ();

    fetch_stage #(.DATAWIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if0)
    );

    fetch_stage #(.DATAWIDTH(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word equals its address, one cycle after the request
    always_ff @(posedge clk) begin
        if0.imem_rdata_i <= if0.imem_re_o ? if0.imem_raddr_o : 32'hDEAD_BEEF;
        if1.imem_rdata_i <= if1.imem_re_o ? if1.imem_raddr_o : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Expect a request at addr and, if vld, a valid head carrying pc=inst=hpc
    task automatic expect0(input string tag, input logic re, input logic [31:0] addr,
                           input logic vld, input logic [31:0] hpc);
        chk({tag, "_re"}, {31'd0, if0.imem_re_o}, {31'd0, re});
        if (re) chk({tag, "_addr"}, if0.imem_raddr_o, addr);
        chk({tag, "_valid"}, {31'd0, if0.valid_o}, {31'd0, vld});
        if (vld) begin
            chk({tag, "_pc"}, if0.pc_o, hpc);
            chk({tag, "_inst"}, if0.inst_o, hpc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if0.ready_i = 1'b1; if0.redirect_i = 1'b0; if0.redirect_pc_i = 32'h0;
        if1.ready_i = 1'b1; if1.redirect_i = 1'b0; if1.redirect_pc_i = 32'h0;

        cyc(); #1;
        expect0("rst", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_inst", if0.inst_o, 32'h0);
        chk("rst_pc", if0.pc_o, 32'h0);
        chk("rst1_re", {31'd0, if1.imem_re_o}, 32'd0);

        // Streaming with ready high; dut1 checks the PC wrap alongside
        cyc(); rst_n = 1'b1; #1;
        expect0("c0", 1'b1, 32'h0, 1'b0, 32'h0);
        chk("wrap_a0", if1.imem_raddr_o, 32'hFFFF_FFF8);
        cyc(); #1;
        expect0("c1", 1'b1, 32'h4, 1'b0, 32'h0);
        chk("wrap_a1", if1.imem_raddr_o, 32'hFFFF_FFFC);
        cyc(); #1;
        expect0("c2", 1'b1, 32'h8, 1'b1, 32'h0);
        chk("wrap_a2", if1.imem_raddr_o, 32'h0000_0000);
        chk("wrap_p0", if1.pc_o, 32'hFFFF_FFF8);
        cyc(); #1;
        expect0("c3", 1'b1, 32'hC, 1'b1, 32'h4);
        chk("wrap_p1", if1.pc_o, 32'hFFFF_FFFC);
        cyc(); #1;
        expect0("c4", 1'b1, 32'h10, 1'b1, 32'h8);
        chk("wrap_p2", if1.pc_o, 32'h0000_0000);
        chk("wrap_i2", if1.inst_o, 32'h0000_0000);

        // Backpressure for 6 cycles: head holds 0x0C, requests stop
        for (int k = 5; k <= 10; k++) begin
            cyc(); if0.ready_i = 1'b0; #1;
            expect0($sformatf("bp%0d", k), 1'b0, 32'h0, 1'b1, 32'hC);
        end
        cyc(); if0.ready_i = 1'b1; #1;
        expect0("c11", 1'b1, 32'h14, 1'b1, 32'hC);
        cyc(); #1;
        expect0("c12", 1'b1, 32'h18, 1'b1, 32'h10);
        cyc(); #1;
        expect0("c13", 1'b1, 32'h1C, 1'b1, 32'h14);
        cyc(); #1;
        expect0("c14", 1'b1, 32'h20, 1'b1, 32'h18);

        // Redirect to 0x100 with one entry buffered and one in flight
        cyc(); if0.redirect_i = 1'b1; if0.redirect_pc_i = 32'h100; #1;
        expect0("r0", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); if0.redirect_i = 1'b0; #1;
        expect0("r1", 1'b1, 32'h100, 1'b0, 32'h0);
        cyc(); #1;
        expect0("r2", 1'b1, 32'h104, 1'b0, 32'h0);
        cyc(); #1;
        expect0("r3", 1'b1, 32'h108, 1'b1, 32'h100);
        cyc(); #1;
        expect0("r4", 1'b1, 32'h10C, 1'b1, 32'h104);

        // Unaligned redirect target
        cyc(); if0.redirect_i = 1'b1; if0.redirect_pc_i = 32'h203; #1;
        expect0("u0", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); if0.redirect_i = 1'b0; #1;
        expect0("u1", 1'b1, 32'h200, 1'b0, 32'h0);
        cyc(); #1;
        expect0("u2", 1'b1, 32'h204, 1'b0, 32'h0);
        cyc(); #1;
        expect0("u3", 1'b1, 32'h208, 1'b1, 32'h200);

        // Back-to-back redirects: 0x40 must never be requested
        cyc(); if0.redirect_i = 1'b1; if0.redirect_pc_i = 32'h40; #1;
        expect0("b0", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); if0.redirect_pc_i = 32'h80; #1;
        expect0("b1", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(); if0.redirect_i = 1'b0; #1;
        expect0("b2", 1'b1, 32'h80, 1'b0, 32'h0);
        cyc(); #1;
        expect0("b3", 1'b1, 32'h84, 1'b0, 32'h0);
        cyc(); #1;
        expect0("b4", 1'b1, 32'h88, 1'b1, 32'h80);
        cyc(); #1;
        expect0("b5", 1'b1, 32'h8C, 1'b1, 32'h84);

        // Async reset between clock edges
        #1; rst_n = 1'b0; #1;
        expect0("ar0", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ar0_re1", {31'd0, if1.imem_re_o}, 32'd0);
        cyc(); #1;
        expect0("ar1", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ar1_pc", if0.pc_o, 32'h0);
        cyc(); rst_n = 1'b1; #1;
        expect0("ar2", 1'b1, 32'h0, 1'b0, 32'h0);
        cyc(); #1;
        expect0("ar3", 1'b1, 32'h4, 1'b0, 32'h0);
        cyc(); #1;
        expect0("ar4", 1'b1, 32'h8, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
